// File: rtl/hamming_pkg.sv
// Shared Hamming SECDED definitions: engine FSM states, widths and the reference encoder.
package hamming_pkg;

    localparam int CW_W  = 16;
    localparam int MSG_W = 11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_LO,
        S_RD_HI,
        S_CAP,
        S_ENC,
        S_WR_LO,
        S_WR_HI,
        S_DONE
    } enc_state_t;

    // Codeword layout puts each parity bit at its Hamming position (1,2,4,8), p0 at bit 0.
    function automatic logic [15:0] hamming_encode(input logic [11:1] d);
        logic p8, p4, p2, p1, p0;
        p8 = ^d[11:5];
        p4 = (^d[11:8]) ^ (^d[4:2]);
        p2 = d[11] ^ d[10] ^ d[7] ^ d[6] ^ d[4] ^ d[3] ^ d[1];
        p1 = d[11] ^ d[9] ^ d[7] ^ d[5] ^ d[4] ^ d[2] ^ d[1];
        p0 = (^d) ^ p8 ^ p4 ^ p2 ^ p1;
        return {d[11:5], p8, d[4:2], p4, d[1], p2, p1, p0};
    endfunction

endpackage

// File: rtl/hamming_enc_core.sv
// Combinational SECDED encoder: 11-bit message in, 16-bit codeword out.
module hamming_enc_core
    import hamming_pkg::*;
(
    input  logic [MSG_W-1:0] msg,
    output logic [CW_W-1:0]  cw
);

    always_comb begin
        cw = hamming_encode(msg);
    end

endmodule

// File: rtl/hamming_enc_engine.sv
// Memory-mapped SECDED encoder: reads NUM_MSG messages, writes codewords back.
// Optional message counter output enc_cnt enabled by `define HAMMING_ENC_CNT_EN.
module hamming_enc_engine
    import hamming_pkg::*;
#(
    parameter int NUM_MSG  = 15,
    parameter int SRC_BASE = 0,
    parameter int DST_BASE = 30,
    parameter int ADDR_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data
`ifdef HAMMING_ENC_CNT_EN
    ,
    output logic [3:0]        enc_cnt
`endif
);

    enc_state_t        state, state_nx;
    logic [3:0]        idx, idx_nx;
    logic [7:0]        lo_q;
    logic [2:0]        hi_q;
    logic [CW_W-1:0]   cw_q, enc_out;
    logic [ADDR_W-1:0] off, addr_nx;
    logic              accept;

    hamming_enc_core u_core (
        .msg (MSG_W'({hi_q, lo_q})),
        .cw  (enc_out)
    );

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        accept   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    accept   = 1'b1;
                    state_nx = S_RD_LO;
                    idx_nx   = '0;
                end
            end
            S_RD_LO: state_nx = S_RD_HI;
            S_RD_HI: state_nx = S_CAP;
            S_CAP:   state_nx = S_ENC;
            S_ENC:   state_nx = S_WR_LO;
            S_WR_LO: state_nx = S_WR_HI;
            S_WR_HI: begin
                if (idx < 4'(NUM_MSG - 1)) begin
                    state_nx = S_RD_LO;
                    idx_nx   = idx + 4'd1;
                end else begin
                    state_nx = S_DONE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Address is registered from the next state so it is presented for the whole state cycle.
    always_comb begin
        off     = ADDR_W'({idx_nx, 1'b0});
        addr_nx = mem_addr;
        case (state_nx)
            S_RD_LO: addr_nx = ADDR_W'(SRC_BASE) + off;
            S_RD_HI: addr_nx = ADDR_W'(SRC_BASE) + off + ADDR_W'(1);
            S_WR_LO: addr_nx = ADDR_W'(DST_BASE) + off;
            S_WR_HI: addr_nx = ADDR_W'(DST_BASE) + off + ADDR_W'(1);
            default: addr_nx = mem_addr;
        endcase
    end

    // Write strobe decodes from state, so an async reset drops it immediately.
    always_comb begin
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        if (state == S_WR_LO) begin
            mem_wr_en   = 1'b1;
            mem_wr_data = cw_q[7:0];
        end else if (state == S_WR_HI) begin
            mem_wr_en   = 1'b1;
            mem_wr_data = cw_q[15:8];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            idx      <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            cw_q     <= '0;
            mem_addr <= '0;
            done     <= 1'b0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            mem_addr <= addr_nx;
            done     <= (state_nx == S_DONE);
            if (state == S_RD_HI) lo_q <= mem_rd_data;
            if (state == S_CAP)   hi_q <= mem_rd_data[2:0];
            if (state == S_ENC)   cw_q <= enc_out;
        end
    end

`ifdef HAMMING_ENC_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            enc_cnt <= '0;
        end else if (accept) begin
            enc_cnt <= '0;
        end else if (state == S_WR_HI) begin
            enc_cnt <= enc_cnt + 4'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hamming_enc_engine.sv
// Bench for hamming_enc_engine: byte memory model, write scoreboard, directed runs.
module tb_hamming_enc_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
`ifdef HAMMING_ENC_CNT_EN
    logic [3:0] enc_cnt;
`endif

    hamming_enc_engine #(
        .NUM_MSG  (15),
        .SRC_BASE (0),
        .DST_BASE (30),
        .ADDR_W   (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
`ifdef HAMMING_ENC_CNT_EN
        ,
        .enc_cnt     (enc_cnt)
`endif
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [256];
    logic [7:0]  img [256];
    logic        load = 1'b0;
    logic [7:0]  msg_lo [15];
    logic [7:0]  msg_hi [15];
    logic [15:0] exp_cw [15];

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t exp_q[$];

    int pass_cnt  = 0;
    int total_cnt = 0;
    int fail_cnt  = 0;

    always @(posedge clk) begin
        if (load) begin
            for (int k = 0; k < 256; k++) mem[k] <= img[k];
        end else begin
            if (mem_wr_en) mem[mem_addr] <= mem_wr_data;
            mem_rd_data <= mem[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference built from Hamming positions, independent of the RTL bit equations.
    function automatic logic [15:0] model_cw(input logic [10:0] d);
        logic [15:0] c;
        int unsigned j;
        logic par;
        c = '0;
        j = 0;
        for (int unsigned k = 1; k < 16; k++) begin
            if ((k & (k - 1)) != 0) begin
                c[k] = d[j];
                j++;
            end
        end
        for (int unsigned p = 1; p < 16; p = p * 2) begin
            par = 1'b0;
            for (int unsigned k = 1; k < 16; k++)
                if (((k & p) != 0) && (k != p)) par = par ^ c[k];
            c[p] = par;
        end
        c[0] = ^c[15:1];
        return c;
    endfunction

    function automatic logic [12:0] model_dec(input logic [15:0] c);
        logic [3:0]  syn;
        logic [10:0] d;
        int unsigned j;
        syn = '0;
        d   = '0;
        j   = 0;
        for (int unsigned k = 1; k < 16; k++) begin
            if (c[k]) syn = syn ^ 4'(k);
            if ((k & (k - 1)) != 0) begin
                d[j] = c[k];
                j++;
            end
        end
        return {(syn != 4'd0), ^c, d};
    endfunction

    always @(negedge clk) begin
        if (!reset && mem_wr_en) begin
            check("write_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", 32'(mem_wr_data), 32'(e.data));
            end
        end
    end

    task automatic load_img();
        for (int k = 0; k < 256; k++) img[k] = 8'h00;
        for (int i = 0; i < 15; i++) begin
            img[2*i]      = msg_lo[i];
            img[2*i+1]    = msg_hi[i];
            img[30+2*i]   = 8'hAA;
            img[30+2*i+1] = 8'hAA;
        end
        @(posedge clk); #1 load = 1'b1;
        @(posedge clk); #1 load = 1'b0;
    endtask

    task automatic push_exp();
        wr_t e;
        for (int i = 0; i < 15; i++) begin
            exp_cw[i] = model_cw({msg_hi[i][2:0], msg_lo[i]});
            e.addr = 8'(30 + 2*i);
            e.data = exp_cw[i][7:0];
            exp_q.push_back(e);
            e.addr = 8'(31 + 2*i);
            e.data = exp_cw[i][15:8];
            exp_q.push_back(e);
        end
    endtask

    task automatic run(input bit pulses);
        int n;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            start = pulses && (n == 10 || n == 47);
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("done_cycles", 32'(n), 32'd90);
        check("done_level", 32'(done), 32'd1);
`ifdef HAMMING_ENC_CNT_EN
        check("enc_cnt_done", 32'(enc_cnt), 32'd15);
`endif
    endtask

    task automatic check_mem();
        for (int i = 0; i < 15; i++) begin
            check($sformatf("mem_lo_%0d", i), 32'(mem[30+2*i]), 32'(exp_cw[i][7:0]));
            check($sformatf("mem_hi_%0d", i), 32'(mem[31+2*i]), 32'(exp_cw[i][15:8]));
        end
    endtask

    initial begin
        #2 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_done", 32'(done), 32'd0);
        check("rst_wr_en", 32'(mem_wr_en), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wr_data", 32'(mem_wr_data), 32'd0);
`ifdef HAMMING_ENC_CNT_EN
        check("rst_enc_cnt", 32'(enc_cnt), 32'd0);
`endif
        reset = 1'b0;

        // all-zero messages
        for (int i = 0; i < 15; i++) begin msg_lo[i] = 8'h00; msg_hi[i] = 8'h00; end
        load_img();
        push_exp();
        run(1'b0);
        check_mem();

        // all-ones data
        msg_lo[0] = 8'hFF; msg_hi[0] = 8'h07;
        load_img();
        push_exp();
        run(1'b0);
        check("d7ff_lo", 32'(mem[30]), 32'h0FF);
        check("d7ff_hi", 32'(mem[31]), 32'h0FF);

        // single-bit messages, garbage in hi[7:3]
        msg_lo[0] = 8'h01; msg_hi[0] = 8'h00;
        msg_lo[1] = 8'h00; msg_hi[1] = 8'hFC;
        load_img();
        push_exp();
        run(1'b0);
        check("d001_lo", 32'(mem[30]), 32'h0F);
        check("d001_hi", 32'(mem[31]), 32'h00);
        check("d400_lo", 32'(mem[32]), 32'h17);
        check("d400_hi", 32'(mem[33]), 32'h81);

        // random messages, round-tripped through a decoder model
        for (int i = 0; i < 15; i++) begin
            msg_lo[i] = 8'($urandom);
            msg_hi[i] = 8'($urandom);
        end
        load_img();
        push_exp();
        run(1'b0);
        check_mem();
        for (int i = 0; i < 15; i++) begin
            logic [12:0] r;
            r = model_dec({mem[31+2*i], mem[30+2*i]});
            check($sformatf("dec_data_%0d", i), 32'(r[10:0]), 32'({msg_hi[i][2:0], msg_lo[i]}));
            check($sformatf("dec_flags_%0d", i), 32'(r[12:11]), 32'd0);
        end

        // reset mid-run, then a full rerun with ignored start pulses
        for (int i = 0; i < 15; i++) begin
            msg_lo[i] = 8'($urandom);
            msg_hi[i] = 8'($urandom);
        end
        load_img();
        push_exp();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (40) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_wr_en", 32'(mem_wr_en), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
`ifdef HAMMING_ENC_CNT_EN
        check("midrst_enc_cnt", 32'(enc_cnt), 32'd0);
`endif
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        repeat (6) @(posedge clk);
        check("idle_after_rst", 32'(done), 32'd0);
        push_exp();
        run(1'b1);
        check_mem();

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
